vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates the 640x480@60 Hz VGA raster timing from the 100 MHz system clock.
- Drives h_cnt, v_cnt, valid, hsync and vsync to the screen renderers (cover and game screens) and to the board VGA pins.
- Also produces the clk_bling blink level that the cover screen uses for its flashing text.
- Sits directly upstream of every pixel-colour block.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); must be at least 2
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- BLINK_FRAMES, 30, frames per clk_bling half-period

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  synchronous, active-low reset
- pix_en  output  1  one-clk pulse marking each pixel slot
- h_cnt  output  10  horizontal pixel counter, 0..799
- v_cnt  output  10  vertical line counter, 0..524
- valid  output  1  high inside the visible 640x480 area
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- frame_start  output  1  one-clk pulse when the raster wraps to (0,0)
- clk_bling  output  1  blink level for flashing text

Behaviour:
- One clock: clk. Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk. Reset has priority over every other event in the same cycle.
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP = 525.
- Divider: div counts 0..CLK_DIV-1 and wraps to 0. pix_en is high in exactly the cycle where div == CLK_DIV-1.
- Horizontal counter: on a clock edge with pix_en high, h_cnt increments. If h_cnt == H_TOTAL-1, it wraps to 0 and the line advances.
- Vertical counter: on a line advance, v_cnt increments. If v_cnt == V_TOTAL-1, it wraps to 0.
- Output timing: valid, hsync and vsync are registered and computed from the next counter values. They therefore change on the same edge as h_cnt/v_cnt, with zero skew relative to the counters.
- valid = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- hsync = 0 iff H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
- vsync = 0 iff V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491.
- frame_start is high for exactly one clk, in the cycle after h_cnt/v_cnt become (0,0) from (799,524). It is never asserted out of reset.
- Blink: an internal frame counter fcnt advances on each frame wrap. When fcnt == BLINK_FRAMES-1 on a wrap, fcnt returns to 0 and clk_bling toggles.
- Reset values: div=0, h_cnt=0, v_cnt=0, fcnt=0, pix_en=0, valid=1, hsync=1, vsync=1, frame_start=0, clk_bling=1.
- Timing after reset release: the first pix_en occurs in clk cycle CLK_DIV-1 after release, and h_cnt reads 1 after that edge.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clk cycles.
- Counters hold their value between pix_en pulses. No output glitches.
- Reset mid-frame: all state returns to reset values on the next edge. No partial line is completed.
- Counter widths are fixed at 10 bits. Parameters must keep H_TOTAL and V_TOTAL ≤ 1024. The div and fcnt widths are sized with $clog2.

Optional Feature:
- Macro: VGA_BLING_EN.
- Defined: clk_bling toggles every BLINK_FRAMES frames as described above (about 1 Hz square wave at defaults). The fcnt counter is present.
- Undefined: fcnt logic is removed and clk_bling is tied to 1, so flashing text renders steadily. All other outputs are unchanged.

Test Plan:
- Reset then release rst_n: all outputs at their reset values. pix_en first high at cycle 3. h_cnt=1 at cycle 4. pix_en period is exactly 4 clk.
- Run one full line: hsync low for exactly 96 pixels starting at h_cnt=656. valid falls on h_cnt=640. h_cnt wraps 799->0 as v_cnt goes 0->1 on the same edge.
- Run one full frame: vsync low only for v_cnt 490..491. valid is low for all v_cnt ≥ 480. frame_start pulses once, 1,680,000 clk cycles after the previous one.
- With VGA_BLING_EN defined and BLINK_FRAMES=2: clk_bling goes 1->0 at the 2nd frame_start and 0->1 at the 4th. Without the macro, clk_bling stays 1 across 4 frames.
- Assert rst_n=0 for one cycle at h_cnt=300, v_cnt=200, coinciding with pix_en: the next edge gives h_cnt=0, v_cnt=0, clk_bling=1, and the counters restart with no extra pix_en.
- Scoreboard check over 3 frames: every clk, valid, hsync and vsync match the formulas applied to the current h_cnt/v_cnt. Zero mismatches are required.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing from the system clock.
// Produces the pixel-slot strobe, h/v counters, valid/hsync/vsync, the
// frame-start pulse and the clk_bling blink level.
// Optional feature macro: VGA_BLING_EN (blink counter present; otherwise
// clk_bling is tied high).
module vga_timing_gen #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned H_VISIBLE    = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_VISIBLE    = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       clk_bling
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = H_VISIBLE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = V_VISIBLE + V_FP + V_SYNC;
    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam int unsigned FCNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Elaboration-time parameter sanity
    if (CLK_DIV < 2) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 2");
    end
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("vga_timing_gen: BLINK_FRAMES must be at least 1");
    end

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             wrap_c;
    logic             wrap_q;

    // Next-state of divider and raster counters
    always_comb begin
        div_nxt = div + 1'b1;
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        wrap_c  = 1'b0;
        if (div == DIV_W'(CLK_DIV - 1)) begin
            div_nxt = '0;
        end
        if (pix_en) begin
            if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
                h_nxt = '0;
                if (v_cnt == CNT_W'(V_TOTAL - 1)) begin
                    v_nxt  = '0;
                    wrap_c = 1'b1;
                end else begin
                    v_nxt = v_cnt + 1'b1;
                end
            end else begin
                h_nxt = h_cnt + 1'b1;
            end
        end
    end

    // Counters and zero-skew registered timing outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div         <= '0;
            pix_en      <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            valid       <= 1'b1;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            wrap_q      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_nxt;
            pix_en      <= (div_nxt == DIV_W'(CLK_DIV - 1));
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            valid       <= (h_nxt < CNT_W'(H_VISIBLE)) && (v_nxt < CNT_W'(V_VISIBLE));
            hsync       <= !((h_nxt >= CNT_W'(HS_START)) && (h_nxt < CNT_W'(HS_END)));
            vsync       <= !((v_nxt >= CNT_W'(VS_START)) && (v_nxt < CNT_W'(VS_END)));
            wrap_q      <= wrap_c;
            frame_start <= wrap_q;
        end
    end

`ifdef VGA_BLING_EN
    logic [FCNT_W-1:0] fcnt;

    // Frame counter toggles the blink level every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt      <= '0;
            clk_bling <= 1'b1;
        end else if (wrap_q) begin
            if (fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
                fcnt      <= '0;
                clk_bling <= !clk_bling;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end
`else
    // Blink disabled: flashing text renders steadily
    localparam logic [FCNT_W-1:0] FCNT_UNUSED = '0;
    assign clk_bling = 1'b1 | (&FCNT_UNUSED);
`endif

endmodule
